nop_inject_ctrl: RTL

//  Issue-side hazard controller between fetch and decode of the branch-free pipeline.

---
 rtl/nop_pkg.sv | 39 +++
 rtl/nop_hazard_detect.sv | 41 ++++
 rtl/nop_inject_ctrl.sv | 109 ++++++++++
 3 files changed

// File: rtl/nop_pkg.sv
// Shared types and constants for the NOP-injection hazard controller.
// Holds RV32 opcode values, the bubble encoding, the history entry and the FSM state type.
package nop_pkg;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h00000013;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    typedef struct packed {
        logic       wen;
        logic [4:0] rd;
    } hist_entry_t;

    typedef enum logic {
        PASS   = 1'b0,
        INJECT = 1'b1
    } state_t;

    // Writes to x0 are discarded, so they never count as producers.
    function automatic hist_entry_t dest_of(input logic [6:0] opcode, input logic [4:0] rd);
        hist_entry_t e;
        e.rd = rd;
        case (opcode)
            OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_LUI,
            OPC_AUIPC, OPC_JAL, OPC_JALR: e.wen = (rd != 5'd0);
            default:                      e.wen = 1'b0;
        endcase
        return e;
    endfunction

endpackage

// File: rtl/nop_hazard_detect.sv
// Combinational RAW check of a fetched instruction's sources against the issue history.
// Produces the number of bubbles still required before the instruction may issue.
module nop_hazard_detect
    import nop_pkg::*;
#(
    parameter int HAZ_WINDOW = 3,
    parameter int CW         = $clog2(HAZ_WINDOW + 1)
) (
    input  logic [6:0]  opcode,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  hist_entry_t hist [HAZ_WINDOW],
    output logic [CW-1:0] need
);

    logic useRs1;
    logic useRs2;

    always_comb begin
        useRs1 = 1'b0;
        useRs2 = 1'b0;
        case (opcode)
            OPC_OP, OPC_STORE, OPC_BRANCH: begin
                useRs1 = 1'b1;
                useRs2 = 1'b1;
            end
            OPC_OP_IMM, OPC_LOAD, OPC_JALR: useRs1 = 1'b1;
            default: ;
        endcase
    end

    // Walk oldest to newest so the nearest producer determines the bubble count.
    always_comb begin
        need = '0;
        for (int i = HAZ_WINDOW - 1; i >= 0; i--) begin
            if (hist[i].wen && ((useRs1 && hist[i].rd == rs1) || (useRs2 && hist[i].rd == rs2)))
                need = CW'(HAZ_WINDOW - i);
        end
    end

endmodule

// File: rtl/nop_inject_ctrl.sv
// Issue-side hazard controller: stalls fetch and emits ADDI x0,x0,0 bubbles on RAW hazards.
// Define NOP_STATS_EN to add the saturating nop_total counter port.
module nop_inject_ctrl
    import nop_pkg::*;
#(
    parameter int          HAZ_WINDOW = 3,
    parameter logic [31:0] NOP_INSTR  = NOP_INSTR_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [31:0] in_instr,
    output logic        in_ready,
    output logic        out_valid,
    output logic [31:0] out_instr,
    input  logic        out_ready,
    output logic        nop_active
`ifdef NOP_STATS_EN
    ,
    output logic [15:0] nop_total
`endif
);

    localparam int CW = $clog2(HAZ_WINDOW + 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   need;
    hist_entry_t     hist [HAZ_WINDOW];
    logic            outIsNop;
    logic            adv;
    logic            emitNop;

    nop_hazard_detect #(
        .HAZ_WINDOW(HAZ_WINDOW),
        .CW        (CW)
    ) u_detect (
        .opcode(in_instr[6:0]),
        .rs1   (in_instr[19:15]),
        .rs2   (in_instr[24:20]),
        .hist  (hist),
        .need  (need)
    );

    assign adv        = !out_valid || out_ready;
    assign in_ready   = !reset && adv && (state == PASS) && in_valid && (need == '0);
    assign emitNop    = !reset && adv && ((state == INJECT) || (in_valid && need != '0));
    assign nop_active = (state == INJECT) || (out_valid && outIsNop);

    // The history shifts once per advancing slot; only a real issued instruction pushes a producer.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= PASS;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_instr <= NOP_INSTR;
            outIsNop  <= 1'b0;
            for (int i = 0; i < HAZ_WINDOW; i++)
                hist[i] <= '0;
        end else if (adv) begin
            for (int i = HAZ_WINDOW - 1; i > 0; i--)
                hist[i] <= hist[i-1];
            hist[0] <= '0;
            case (state)
                PASS: begin
                    if (in_valid && need == '0) begin
                        out_instr <= in_instr;
                        out_valid <= 1'b1;
                        outIsNop  <= 1'b0;
                        hist[0]   <= dest_of(in_instr[6:0], in_instr[11:7]);
                    end else if (in_valid) begin
                        out_instr <= NOP_INSTR;
                        out_valid <= 1'b1;
                        outIsNop  <= 1'b1;
                        cnt       <= need - ONE;
                        state     <= (need > ONE) ? INJECT : PASS;
                    end else begin
                        out_valid <= 1'b0;
                        outIsNop  <= 1'b0;
                    end
                end
                INJECT: begin
                    out_instr <= NOP_INSTR;
                    out_valid <= 1'b1;
                    outIsNop  <= 1'b1;
                    cnt       <= cnt - ONE;
                    if (cnt == ONE)
                        state <= PASS;
                end
                default: state <= PASS;
            endcase
        end
    end

`ifdef NOP_STATS_EN
    // Counts every emitted bubble and sticks at all-ones.
    always_ff @(posedge clock) begin
        if (reset)
            nop_total <= '0;
        else if (emitNop && nop_total != 16'hFFFF)
            nop_total <= nop_total + 16'd1;
    end
`else
    logic unusedEmit;
    assign unusedEmit = emitNop;
`endif

endmodule
